// File: rtl/bip_program_loader.sv
// Packs UART byte pairs (high byte first) into instruction words and writes them to program memory from address 0 until an HLT word.
// Latency: low-byte strobe at cycle N gives o_mem_we at N+1. No backpressure: bytes are accepted whenever they arrive, and a byte arriving during the write cycle is kept.
module bip_program_loader #(
    parameter int OPCODE  = 5,
    parameter int OPERAND = 11,
    parameter int INST_W  = OPCODE + OPERAND,
    parameter int ADDR_W  = 11,
    parameter int BYTE_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [BYTE_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [INST_W-1:0] o_mem_data,
    output logic              o_mem_we,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cpu_en,
    output logic              o_err,
    output logic [ADDR_W:0]   o_count
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WAIT_HI = 3'd1;
    localparam logic [2:0] WAIT_LO = 3'd2;
    localparam logic [2:0] WRITE   = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;
    localparam logic [2:0] ERROR   = 3'd5;

    localparam logic [OPCODE-1:0] HLT      = '0;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INST_W-1:0] data_q, data_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_en_q, cpu_en_d;
    logic              is_hlt;

    assign is_hlt = (data_q[INST_W-1 -: OPCODE] == HLT);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        count_d  = count_q;
        done_d   = done_q;
        err_d    = err_q;
        cpu_en_d = cpu_en_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                // Start always wins over a coincident byte, which is dropped.
                if (i_start) begin
                    state_d  = WAIT_HI;
                    addr_d   = '0;
                    count_d  = '0;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    cpu_en_d = 1'b0;
                end
            end
            WAIT_HI: begin
                if (i_rx_valid) begin
                    data_d[INST_W-1 -: BYTE_W] = i_rx_data;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (i_rx_valid) begin
                    data_d[BYTE_W-1:0] = i_rx_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                count_d = count_q + CNT_ONE;
                if (is_hlt) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    cpu_en_d = 1'b1;
                end else if (addr_q == ADDR_MAX) begin
                    state_d  = ERROR;
                    err_d    = 1'b1;
                    cpu_en_d = 1'b0;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                    // A byte arriving while writing is the next word's high byte.
                    if (i_rx_valid) begin
                        data_d[INST_W-1 -: BYTE_W] = i_rx_data;
                        state_d = WAIT_LO;
                    end else begin
                        state_d = WAIT_HI;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cpu_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            count_q  <= count_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cpu_en_q <= cpu_en_d;
        end
    end

    assign o_mem_addr = addr_q;
    assign o_mem_data = data_q;
    assign o_mem_we   = (state_q == WRITE);
    assign o_busy     = (state_q == WAIT_HI) || (state_q == WAIT_LO) || (state_q == WRITE);
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_cpu_en   = cpu_en_q;
    assign o_count    = count_q;

endmodule

// File: tb/tb_bip_program_loader.sv
// Scoreboarded bench for bip_program_loader with a small (3-bit) address space so the overflow path is reachable.
module tb_bip_program_loader;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          mem_we;
    logic          busy;
    logic          done;
    logic          cpu_en;
    logic          err;
    logic [AW:0]   count;

    int checks = 0;
    int failures = 0;
    logic [AW+15:0] exp_q[$];
    logic [AW+15:0] exp_e;

    bip_program_loader #(.ADDR_W(AW)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_mem_addr (mem_addr),
        .o_mem_data (mem_data),
        .o_mem_we   (mem_we),
        .o_busy     (busy),
        .o_done     (done),
        .o_cpu_en   (cpu_en),
        .o_err      (err),
        .o_count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the oldest expected (addr,data) pair.
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=0x%0h data=0x%0h required none at %0t",
                         mem_addr, mem_data, $time);
            end else begin
                exp_e = exp_q.pop_front();
                chk("wr_addr", int'(mem_addr), int'(exp_e[AW+15:16]));
                chk("wr_data", int'(mem_data), int'(exp_e[15:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic exp_wr(input int a, input int d);
        logic [AW-1:0] av;
        logic [15:0]   dv;
        av = AW'(a);
        dv = 16'(d);
        exp_q.push_back({av, dv});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   int'(busy),     0);
        chk({tag, "_we"},     int'(mem_we),   0);
        chk({tag, "_addr"},   int'(mem_addr), 0);
        chk({tag, "_data"},   int'(mem_data), 0);
        chk({tag, "_count"},  int'(count),    0);
        chk({tag, "_done"},   int'(done),     0);
        chk({tag, "_cpu_en"}, int'(cpu_en),   0);
        chk({tag, "_err"},    int'(err),      0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic program: LDI 5, ADDI 3, HLT
        pulse_start();
        chk("t1_busy", int'(busy), 1);
        exp_wr(0, 16'h1805);
        exp_wr(1, 16'h2803);
        exp_wr(2, 16'h0000);
        send(8'h18); tick(); send(8'h05); tick();
        send(8'h28); tick(); send(8'h03); tick();
        send(8'h00); tick(); send(8'h00);
        chk("t1_we_hlt", int'(mem_we), 1);
        chk("t1_done_early", int'(done), 0);
        tick();
        chk("t1_done", int'(done), 1);
        chk("t1_cpu_en", int'(cpu_en), 1);
        chk("t1_count", int'(count), 3);
        chk("t1_busy_end", int'(busy), 0);
        send(8'h11); tick();
        chk("t1_done_hold", int'(done), 1);

        // Restart from DONE, then back-to-back bytes including one during WRITE
        pulse_start();
        chk("t2_cpu_en_drop", int'(cpu_en), 0);
        chk("t2_done_drop", int'(done), 0);
        chk("t2_count_clr", int'(count), 0);
        exp_wr(0, 16'h0801);
        exp_wr(1, 16'h1002);
        exp_wr(2, 16'h0000);
        send(8'h08); send(8'h01); send(8'h10); send(8'h02); send(8'h00); send(8'h00);
        tick();
        chk("t2_done", int'(done), 1);
        chk("t2_count", int'(count), 3);

        // Start while in WAIT_LO is ignored
        pulse_start();
        exp_wr(0, 16'h1805);
        exp_wr(1, 16'h0000);
        send(8'h18); tick();
        pulse_start();
        chk("t4_busy", int'(busy), 1);
        send(8'h05); tick();
        send(8'h00); tick(); send(8'h00); tick();
        chk("t4_done", int'(done), 1);
        chk("t4_count", int'(count), 2);

        // Start with a coincident byte: byte dropped; HLT first word; byte during HLT write discarded
        start = 1'b1; rx_valid = 1'b1; rx_data = 8'h33;
        tick();
        start = 1'b0; rx_valid = 1'b0;
        chk("t6_busy", int'(busy), 1);
        exp_wr(0, 16'h0000);
        send(8'h00); send(8'h00); send(8'h55);
        chk("t6_done", int'(done), 1);
        chk("t6_count", int'(count), 1);
        chk("t6_busy_end", int'(busy), 0);

        // Fill all eight addresses without HLT
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            exp_wr(i, 16'h0801);
            send(8'h08); send(8'h01); tick();
        end
        chk("t3_err", int'(err), 1);
        chk("t3_cpu_en", int'(cpu_en), 0);
        chk("t3_done", int'(done), 0);
        chk("t3_count", int'(count), 8);
        chk("t3_busy", int'(busy), 0);
        send(8'h08); send(8'h01); tick();
        chk("t3_err_hold", int'(err), 1);
        pulse_start();
        chk("t3_err_drop", int'(err), 0);
        chk("t3_restart_busy", int'(busy), 1);

        // Async reset between high and low byte
        exp_wr(0, 16'h0801);
        send(8'h08); send(8'h01); tick();
        send(8'h18);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send(8'h00); send(8'h00); tick();
        chk("t5_stray_busy", int'(busy), 0);
        chk("t5_stray_count", int'(count), 0);

        // Load after reset: HLT as first word
        pulse_start();
        exp_wr(0, 16'h0000);
        send(8'h00); send(8'h00); tick();
        chk("t7_done", int'(done), 1);
        chk("t7_count", int'(count), 1);
        chk("t7_cpu_en", int'(cpu_en), 1);

        tick(); tick(); tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
